updown_key_counter: RTL and testbench
=====================================

# updown_key_counter

Parametrised up/down counter controller driven by two push-button inputs, for the board-level datapath examples. It replaces the fixed 2-bit increment/decrement state machine and the slow derived clock with the following:
- a WIDTH-bit counter on the single system clock, gated by a sample-enable tick;
- per-button synchronisation, debouncing and press-edge detection;
- selectable wrap or saturate behaviour, a synchronous parallel load, and status flags for LEDs.

## Interface
- WIDTH, 4: counter width in bits (≥1).
- MAX_VALUE, 2**WIDTH-1: upper count limit (1..2**WIDTH-1); the count range is 0..MAX_VALUE.
- DEBOUNCE_TICKS, 4: number of consecutive ticks (≥1) a synchronised button level must hold before it is accepted.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.

- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  reset, asynchronous, active-low.
- tick  input  1  sample enable for the debouncers (for example a divided-clock strobe); 1 = sample this cycle.
- inc_n  input  1  increment button, active-low, asynchronous to CLOCK_50.
- dec_n  input  1  decrement button, active-low, asynchronous to CLOCK_50.
- load  input  1  synchronous load strobe, active-high.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count.
- odd  output  1  count[0].
- at_min  output  1  high when count == 0.
- at_max  output  1  high when count == MAX_VALUE.
- wrapped  output  1  one-cycle pulse on the cycle after a wrap, in either direction.

## Operation
- Synchroniser: each button passes through its own 2-flop synchroniser, clocked every cycle (not gated by tick).
- Debouncer, one per button:
  - Holds a stable level plus a tick counter.
  - While the synchronised level differs from the stable level, each cycle with tick=1 increments the counter.
  - Whenever the two levels are equal, the counter clears to 0.
  - When a tick arrives with the counter at DEBOUNCE_TICKS-1 and the levels still differ, the stable level takes the synchronised value and the counter clears.
- Press event: a stable-level transition from released to pressed produces one event. Release transitions produce no event.
- Count update priority, applied each cycle:
  1. load=1: count ← min(load_value, MAX_VALUE). Any button events in the same cycle are discarded, not deferred.
  2. Increment and decrement events in the same cycle: count unchanged, wrapped=0.
  3. Increment event: count+1. At MAX_VALUE: wraps to 0 with wrapped=1 (SATURATE=0), or holds (SATURATE=1).
  4. Decrement event: count-1. At 0: wraps to MAX_VALUE with wrapped=1 (SATURATE=0), or holds (SATURATE=1).
- Arithmetic: the limit compare is done before any add or subtract, so an out-of-range count is never produced, including when MAX_VALUE < 2**WIDTH-1.
- Flags: odd, at_min and at_max are combinational from the count register.
- Holding a button produces exactly one event. Bounces shorter than DEBOUNCE_TICKS ticks produce none.

## Timing
- Reset values: count=0, odd=0, at_min=1, at_max=0, wrapped=0. Synchronisers, stable levels and previous-stable registers all reset to released; debounce counters reset to 0.
- Reset asserted mid-operation clears everything immediately, including partially debounced presses. No event is generated at reset release, even if a button is held; a held button must be released and pressed again to count.
- Latency with tick held at 1: inc_n falls before edge 0 → synchroniser output at edge 1 → stable level flips at edge DEBOUNCE_TICKS+1 → count changes at edge DEBOUNCE_TICKS+2. For DEBOUNCE_TICKS=4, the new count is visible after edge 6.
- With a sparse tick, latency is 2 cycles of synchronisation, plus DEBOUNCE_TICKS tick pulses, plus 1 cycle.
- load: count is updated at the edge where load=1 is sampled; the flags follow in the same cycle.
- wrapped is registered: it is high for exactly the one cycle after the edge on which the wrap occurred.
- A press that becomes stable in the same cycle as load=1 is lost.

## Test plan
- Reset with WIDTH=4, DEBOUNCE_TICKS=4, tick=1: hold inc_n low. Required: count=0 and at_min=1 throughout reset and after release, with no increment.
- Clean press: drop inc_n low for 10 cycles. Required: count 0→1 at edge 6 (DEBOUNCE_TICKS+2), exactly one increment, odd=1.
- Bounce: toggle inc_n low for 2 cycles, high for 1, three times, then hold low. Required: a single increment, debounced from the final stable low.
- Wrap and saturate:
  - SATURATE=0, load 15, one inc press → count=0, wrapped pulses for 1 cycle; then one dec press → count=15, wrapped=1.
  - SATURATE=1, same sequence → count stays at 15 with wrapped=0; count=0 with one dec press → stays 0.
- MAX_VALUE=9, WIDTH=4: load 12 → count=9, at_max=1; one inc press → count=0.
- Simultaneous events:
  - inc and dec stable on the same edge → count unchanged.
  - A stable inc coinciding with load=1, load_value=5 → count=5, with no extra increment afterwards.
  - RESET_N pulsed low mid-debounce → count=0, and no event after release.

Source files
------------

// File: rtl/updown_key_counter.sv
// updown_key_counter: two-button up/down counter with sync, debounce,
// press-edge detect, wrap/saturate limits, parallel load and LED flags.
// Ports: CLOCK_50, RESET_N (async, low), tick (debounce sample enable),
//        inc_n/dec_n (active-low buttons), load/load_value (sync load),
//        count, odd, at_min, at_max, wrapped (pulse after a wrap).
module updown_key_counter #(
   parameter int WIDTH          = 4,
   parameter int MAX_VALUE      = (2**WIDTH)-1,
   parameter int DEBOUNCE_TICKS = 4,
   parameter bit SATURATE       = 1'b0
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             tick,
   input  logic             inc_n,
   input  logic             dec_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             odd,
   output logic             at_min,
   output logic             at_max,
   output logic             wrapped
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);

   // index 0 = increment button, index 1 = decrement button
   logic [1:0]    btn;
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    stable;
   logic [1:0]    prev;
   logic [1:0]    armed;
   logic [1:0]    warm;
   logic [1:0]    pe;
   logic [CW-1:0] cnt [2];

   logic do_load;
   logic do_inc;
   logic do_dec;

   assign btn = {dec_n, inc_n};

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         s1     <= 2'b11;
         s2     <= 2'b11;
         stable <= 2'b11;
         prev   <= 2'b11;
         armed  <= 2'b00;
         warm   <= 2'b00;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         prev <= stable;
         warm <= {warm[0], 1'b1};
         for (int i = 0; i < 2; i++) begin
            // A button must be seen released after reset before its
            // presses count, so a button held through reset is ignored.
            if (warm[1] && s2[i]) armed[i] <= 1'b1;
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (tick) begin
               if (cnt[i] == LAST) begin
                  stable[i] <= s2[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   // press = stable level went released (1) -> pressed (0)
   assign pe = armed & prev & ~stable;

   assign do_load = load;
   assign do_inc  = !load && pe[0] && !pe[1];
   assign do_dec  = !load && pe[1] && !pe[0];

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         count   <= '0;
         wrapped <= 1'b0;
      end else begin
         wrapped <= 1'b0;
         unique case (1'b1)
            do_load: begin
               count <= (load_value > MAX) ? MAX : load_value;
            end
            do_inc: begin
               // limit compare first so no out-of-range value is formed
               if (count >= MAX) begin
                  if (!SATURATE) begin
                     count   <= '0;
                     wrapped <= 1'b1;
                  end
               end else begin
                  count <= count + WIDTH'(1);
               end
            end
            do_dec: begin
               if (count == '0) begin
                  if (!SATURATE) begin
                     count   <= MAX;
                     wrapped <= 1'b1;
                  end
               end else begin
                  count <= count - WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign odd    = count[0];
   assign at_min = (count == '0);
   assign at_max = (count == MAX);

endmodule

// File: tb/tb_updown_key_counter.sv
// tb_updown_key_counter: scoreboard bench for three counter variants
// (wrap, saturate, MAX_VALUE=9) sharing one stimulus stream.
module tb_updown_key_counter;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick  = 1'b1;
   logic       inc_n = 1'b1;
   logic       dec_n = 1'b1;
   logic       load  = 1'b0;
   logic [3:0] lv    = '0;

   logic [3:0] cnt  [3];
   logic       odd  [3];
   logic       amin [3];
   logic       amax [3];
   logic       wrp  [3];

   always #5 clk = ~clk;

   updown_key_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
      .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick),
      .inc_n(inc_n), .dec_n(dec_n), .load(load), .load_value(lv),
      .count(cnt[0]), .odd(odd[0]), .at_min(amin[0]),
      .at_max(amax[0]), .wrapped(wrp[0]));

   updown_key_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
      .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick),
      .inc_n(inc_n), .dec_n(dec_n), .load(load), .load_value(lv),
      .count(cnt[1]), .odd(odd[1]), .at_min(amin[1]),
      .at_max(amax[1]), .wrapped(wrp[1]));

   updown_key_counter #(.WIDTH(4), .MAX_VALUE(9)) u_max9 (
      .CLOCK_50(clk), .RESET_N(rst_n), .tick(tick),
      .inc_n(inc_n), .dec_n(dec_n), .load(load), .load_value(lv),
      .count(cnt[2]), .odd(odd[2]), .at_min(amin[2]),
      .at_max(amax[2]), .wrapped(wrp[2]));

   typedef struct {
      string tag;
      int    inst;
      int    fld;
      int    exp;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs(input int i, input int f);
      case (f)
         0: return 32'(cnt[i]);
         1: return 32'(odd[i]);
         2: return 32'(amin[i]);
         3: return 32'(amax[i]);
         4: return 32'(wrp[i]);
         default: return '1;
      endcase
   endfunction

   task automatic want(input string tag, input int inst,
                       input int f, input int e);
      exp_t x;
      x.tag  = tag;
      x.inst = inst;
      x.fld  = f;
      x.exp  = e;
      sbq.push_back(x);
   endtask

   task automatic want_all(input string tag, input int f,
                           input int ea, input int eb, input int ec);
      want($sformatf("%s_wrap", tag), 0, f, ea);
      want($sformatf("%s_sat", tag), 1, f, eb);
      want($sformatf("%s_max9", tag), 2, f, ec);
   endtask

   task automatic drain();
      exp_t x;
      while (sbq.size() > 0) begin
         x = sbq.pop_front();
         chk(x.tag, obs(x.inst, x.fld), x.exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [3:0] v);
      load = 1'b1;
      lv   = v;
      cyc(1);
      load = 1'b0;
   endtask

   // Press one or both buttons; queued expectations are compared
   // right after the edge where the debounced event takes effect.
   task automatic press(input bit i, input bit d,
                        input bit ld, input logic [3:0] v);
      if (i) inc_n = 1'b0;
      if (d) dec_n = 1'b0;
      cyc(6);
      if (ld) begin
         load = 1'b1;
         lv   = v;
      end
      cyc(1);
      load = 1'b0;
      drain();
      cyc(1);
      want_all("wrp_end", 4, 0, 0, 0);
      drain();
      cyc(3);
      inc_n = 1'b1;
      dec_n = 1'b1;
      cyc(10);
   endtask

   initial begin
      rst_n = 1'b0;
      inc_n = 1'b0;
      cyc(3);
      want_all("rst_cnt", 0, 0, 0, 0);
      want_all("rst_min", 2, 1, 1, 1);
      want_all("rst_wrp", 4, 0, 0, 0);
      drain();
      rst_n = 1'b1;
      cyc(15);
      want_all("held_cnt", 0, 0, 0, 0);
      want_all("held_min", 2, 1, 1, 1);
      drain();
      inc_n = 1'b1;
      cyc(12);
      want_all("rel_cnt", 0, 0, 0, 0);
      drain();

      inc_n = 1'b0;
      cyc(6);
      want_all("lat5", 0, 0, 0, 0);
      drain();
      cyc(1);
      want_all("lat6", 0, 1, 1, 1);
      want_all("odd", 1, 1, 1, 1);
      want_all("min_clr", 2, 0, 0, 0);
      drain();
      cyc(3);
      inc_n = 1'b1;
      cyc(10);
      want_all("once", 0, 1, 1, 1);
      drain();

      repeat (3) begin
         inc_n = 1'b0;
         cyc(2);
         inc_n = 1'b1;
         cyc(1);
      end
      want_all("bnc_none", 0, 1, 1, 1);
      drain();
      want_all("bnc_one", 0, 2, 2, 2);
      press(1'b1, 1'b0, 1'b0, 4'd0);

      do_load(4'd15);
      want_all("ld15", 0, 15, 15, 9);
      want_all("ld15_max", 3, 1, 1, 1);
      want_all("ld15_w", 4, 0, 0, 0);
      drain();
      want_all("inc_lim", 0, 0, 15, 0);
      want_all("inc_lim_w", 4, 1, 0, 1);
      press(1'b1, 1'b0, 1'b0, 4'd0);
      want_all("dec_lim", 0, 15, 14, 9);
      want_all("dec_lim_w", 4, 1, 0, 1);
      press(1'b0, 1'b1, 1'b0, 4'd0);

      do_load(4'd0);
      want_all("ld0", 0, 0, 0, 0);
      want_all("ld0_min", 2, 1, 1, 1);
      drain();
      want_all("dec_zero", 0, 15, 0, 9);
      want_all("dec_zero_w", 4, 1, 0, 1);
      press(1'b0, 1'b1, 1'b0, 4'd0);

      do_load(4'd12);
      want_all("ld12", 0, 12, 12, 9);
      want_all("ld12_max", 3, 0, 0, 1);
      drain();
      want_all("inc12", 0, 13, 13, 0);
      want_all("inc12_w", 4, 0, 0, 1);
      press(1'b1, 1'b0, 1'b0, 4'd0);

      want_all("both", 0, 13, 13, 0);
      want_all("both_w", 4, 0, 0, 0);
      press(1'b1, 1'b1, 1'b0, 4'd0);

      want_all("ld_vs_inc", 0, 5, 5, 5);
      want_all("ld_vs_inc_w", 4, 0, 0, 0);
      press(1'b1, 1'b0, 1'b1, 4'd5);
      want_all("no_extra", 0, 5, 5, 5);
      drain();

      inc_n = 1'b0;
      cyc(3);
      rst_n = 1'b0;
      cyc(2);
      want_all("rst_mid", 0, 0, 0, 0);
      drain();
      inc_n = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      cyc(15);
      want_all("rst_after", 0, 0, 0, 0);
      want_all("rst_after_min", 2, 1, 1, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
